// File: rtl/riscv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_wb_arbiter
// Description : Writeback arbiter for the single register-file write port.
//               It merges ALU results with buffered load results and keeps the
//               busy scoreboard for rs1/rs2. Optional forwarding is enabled
//               with macro WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_wb_arbiter #(
    parameter int WORD_LENGTH    = 32,
    parameter int ADDR_LENGTH    = 5,
    parameter int NUM_REGS       = 32,
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_LENGTH-1:0] alu_rd,
    input  logic [WORD_LENGTH-1:0] alu_data,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [ADDR_LENGTH-1:0] lsu_rd,
    input  logic [WORD_LENGTH-1:0] lsu_data,
    input  logic                   issue_valid,
    input  logic [ADDR_LENGTH-1:0] issue_rd,
    input  logic [ADDR_LENGTH-1:0] rs1_addr,
    input  logic [ADDR_LENGTH-1:0] rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   write_en,
    output logic [ADDR_LENGTH-1:0] write_addr,
    output logic [WORD_LENGTH-1:0] data
`ifdef WB_BYPASS_EN
    ,
    output logic                   fwd1_hit,
    output logic                   fwd2_hit,
    output logic [WORD_LENGTH-1:0] fwd1_data,
    output logic [WORD_LENGTH-1:0] fwd2_data
`endif
);

    localparam int c_ptr_w = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(LSU_FIFO_DEPTH + 1);
    localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);
    localparam int c_ent_w = ADDR_LENGTH + WORD_LENGTH;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(LSU_FIFO_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(LSU_FIFO_DEPTH);
    localparam logic [c_stv_w-1:0] c_starve   = c_stv_w'(STARVE_LIMIT);

    logic [c_ent_w-1:0]     fifo_q [LSU_FIFO_DEPTH];
    logic [c_ent_w-1:0]     fifo_d [LSU_FIFO_DEPTH];
    logic [c_ptr_w-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]     count_q, count_d;
    logic [c_stv_w-1:0]     starve_q, starve_d;
    logic                   write_en_q, write_en_d;
    logic [ADDR_LENGTH-1:0] write_addr_q, write_addr_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [NUM_REGS-1:0]    busy_q, busy_d;

    logic                   w_push, w_pop, w_alu_grant, w_fifo_empty;
    logic [ADDR_LENGTH-1:0] w_head_rd;
    logic [WORD_LENGTH-1:0] w_head_data;
    logic                   w_rs1_sb, w_rs2_sb, w_hit1, w_hit2;

    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    assign alu_ready  = (starve_q != c_starve);
    assign lsu_ready  = (count_q != c_depth);
    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign data       = data_q;

    always_comb begin
        w_alu_grant  = alu_valid && alu_ready;
        w_push       = lsu_valid && lsu_ready;
        w_fifo_empty = (count_q == '0);
        // Only registered count gates the pop, so a fresh push waits one edge.
        w_pop        = !w_alu_grant && !w_fifo_empty;
        {w_head_rd, w_head_data} = fifo_q[rd_ptr_q];

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = {lsu_rd, lsu_data};
            wr_ptr_d         = ptr_next(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        starve_d = starve_q;
        if (w_pop || w_fifo_empty) begin
            starve_d = '0;
        end else if (w_alu_grant) begin
            starve_d = starve_q + 1'b1;
        end

        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        data_d       = data_q;
        if (w_alu_grant) begin
            write_en_d   = (alu_rd != '0);
            write_addr_d = alu_rd;
            data_d       = alu_data;
        end else if (w_pop) begin
            write_en_d   = (w_head_rd != '0);
            write_addr_d = w_head_rd;
            data_d       = w_head_data;
        end

        // Clear on commit first so a same-edge issue of that register wins.
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (write_en_q && write_addr_q == ADDR_LENGTH'(i)) busy_d[i] = 1'b0;
            if (issue_valid && issue_rd == ADDR_LENGTH'(i))    busy_d[i] = 1'b1;
        end
    end

    always_comb begin
        w_rs1_sb = 1'b0;
        w_rs2_sb = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rs1_addr == ADDR_LENGTH'(i)) w_rs1_sb = busy_q[i];
            if (rs2_addr == ADDR_LENGTH'(i)) w_rs2_sb = busy_q[i];
        end
`ifdef WB_BYPASS_EN
        w_hit1 = write_en_q && (write_addr_q != '0) && (write_addr_q == rs1_addr);
        w_hit2 = write_en_q && (write_addr_q != '0) && (write_addr_q == rs2_addr);
`else
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
`endif
        rs1_busy = w_rs1_sb && !w_hit1;
        rs2_busy = w_rs2_sb && !w_hit2;
    end

`ifdef WB_BYPASS_EN
    assign fwd1_hit  = w_hit1;
    assign fwd2_hit  = w_hit2;
    assign fwd1_data = data_q;
    assign fwd2_data = data_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q       <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            data_q       <= '0;
            busy_q       <= '0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
        end
    end

endmodule
`default_nettype wire
